// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the data-phase FSM state type for the SRAM responder.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_t;

endpackage

// File: rtl/ahb_sram_mem.sv
// DEPTH x 32 word array: byte-enabled synchronous write, asynchronous read.
module ahb_sram_mem #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with configurable wait states.
// Define AHB_SRAM_ERR_EN to enable the two-cycle ERROR response on illegal accesses.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned AW          = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic          ready_q;
   logic          pend_q;
   logic          write_q;
   logic [AW-1:0] idx_q;
   logic [1:0]    lo_q;
   logic [1:0]    size_q;

   logic          accept;
   logic          acc_err;
   logic [1:0]    acc_size;
   logic [1:0]    acc_lo;
   logic          complete;
   logic [3:0]    be;
   logic [31:0]   rdata;

   logic          unused_inputs;
   assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HADDR, HTRANS[0]};

   // A stalled data phase of our own masks any address phase on the bus.
   assign accept   = HSEL & HREADY & HTRANS[1] & ready_q;
   assign acc_size = (HSIZE > HSIZE_WORD) ? 2'd2 : HSIZE[1:0];

   always_comb begin
      acc_lo = 2'b00;
      case (acc_size)
         2'd0:    acc_lo = HADDR[1:0];
         2'd1:    acc_lo = {HADDR[1], 1'b0};
         default: acc_lo = 2'b00;
      endcase
   end

`ifdef AHB_SRAM_ERR_EN
   logic resp_q;
   assign acc_err = ((HADDR >> (AW + 2)) != 32'd0) || (HSIZE > HSIZE_WORD) ||
                    ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                    ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
   assign HRESP   = resp_q;
`else
   assign acc_err = 1'b0;
   assign HRESP   = HRESP_OKAY;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         ready_q <= 1'b1;
         pend_q  <= 1'b0;
         write_q <= 1'b0;
         idx_q   <= '0;
         lo_q    <= 2'b00;
         size_q  <= 2'd0;
`ifdef AHB_SRAM_ERR_EN
         resp_q  <= HRESP_OKAY;
`endif
      end else begin
         if (complete) pend_q <= 1'b0;
         if (accept) begin
            idx_q   <= HADDR[AW+1:2];
            lo_q    <= acc_lo;
            size_q  <= acc_size;
            write_q <= HWRITE;
            pend_q  <= ~acc_err;
         end
`ifdef AHB_SRAM_ERR_EN
         if (accept && acc_err) begin
            state_q <= StErr1;
            ready_q <= 1'b0;
            resp_q  <= HRESP_ERROR;
         end else
`endif
         if (accept && (WAIT_STATES > 0)) begin
            state_q <= StWait;
            cnt_q   <= WS_LOAD;
            ready_q <= 1'b0;
`ifdef AHB_SRAM_ERR_EN
            resp_q  <= HRESP_OKAY;
`endif
         end else begin
            case (state_q)
               StWait: begin
                  if (cnt_q == 4'd0) begin
                     state_q <= StIdle;
                     ready_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
`ifdef AHB_SRAM_ERR_EN
               StErr1: begin
                  state_q <= StErr2;
                  ready_q <= 1'b1;
               end
`endif
               default: begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
`ifdef AHB_SRAM_ERR_EN
                  resp_q  <= HRESP_OKAY;
`endif
               end
            endcase
         end
      end
   end

   assign complete = pend_q & (state_q == StIdle);

   always_comb begin
      be = 4'b1111;
      case (size_q)
         2'd0:    be = 4'b0001 << lo_q;
         2'd1:    be = lo_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   ahb_sram_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (complete & write_q),
      .be    (be),
      .addr  (idx_q),
      .wdata (HWDATA),
      .rdata (rdata)
   );

   assign HREADYOUT = ready_q;
   assign HRDATA    = (complete & ~write_q) ? rdata : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: instance 0 has no wait states, instance 1 has three.
module tb_ahb_sram_slave;

   typedef struct packed {
      logic [31:0] rdata;
      logic        resp;
      logic [7:0]  stalls;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [31:0] hwdata    [2];
   logic        hreadyout [2];
   logic        hresp     [2];
   logic [31:0] hrdata    [2];

   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;
   logic dph [2];
   int   stl [2];

   always #5 clk = ~clk;

   ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
      .clk (clk), .reset (reset), .HSEL (hsel[0]), .HADDR (haddr[0]), .HTRANS (htrans[0]),
      .HWRITE (hwrite[0]), .HSIZE (hsize[0]), .HBURST (3'd0), .HPROT (4'd0), .HMASTLOCK (1'b0),
      .HWDATA (hwdata[0]), .HREADY (hreadyout[0]), .HREADYOUT (hreadyout[0]),
      .HRESP (hresp[0]), .HRDATA (hrdata[0])
   );

   ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
      .clk (clk), .reset (reset), .HSEL (hsel[1]), .HADDR (haddr[1]), .HTRANS (htrans[1]),
      .HWRITE (hwrite[1]), .HSIZE (hsize[1]), .HBURST (3'd0), .HPROT (4'd0), .HMASTLOCK (1'b0),
      .HWDATA (hwdata[1]), .HREADY (hreadyout[1]), .HREADYOUT (hreadyout[1]),
      .HRESP (hresp[1]), .HRDATA (hrdata[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive an address phase, wait until it is accepted, then drive its write data.
   task automatic issue(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [31:0] er, input logic eresp,
                        input int est, input bit push);
      int   n;
      exp_t e;
      hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
      n = 0;
      @(negedge clk);
      while (!hreadyout[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
      if (push) begin
         e.rdata = er; e.resp = eresp; e.stalls = 8'(est);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      hwdata[d] = wd;
   endtask

   task automatic idle(input int d, input int cycles);
      int n;
      hsel[d] = 1'b0; htrans[d] = 2'b00;
      n = 0;
      @(negedge clk);
      while (!hreadyout[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("idle_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Monitor: tracks data phases from the bus and pops the scoreboard on completion.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            dph[d] = 1'b0;
            stl[d] = 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (dph[d]) begin
               if (hreadyout[d]) begin
                  if (sb.size() == 0) begin
                     chk("unexpected_completion", 32'd1, 32'd0);
                  end else begin
                     e = sb.pop_front();
                     chk("hrdata", hrdata[d], e.rdata);
                     chk("hresp", 32'(hresp[d]), 32'(e.resp));
                     chk("stall_cycles", 32'(stl[d]), 32'(e.stalls));
                  end
                  stl[d] = 0;
               end else begin
                  stl[d]++;
                  if (sb.size() > 0) chk("hresp_stall", 32'(hresp[d]), 32'(sb[0].resp));
               end
            end else begin
               chk("idle_bus", {hreadyout[d], hresp[d], hrdata[d]}, {1'b1, 1'b0, 32'd0});
            end
            if (hreadyout[d]) dph[d] = hsel[d] & htrans[d][1];
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         hsel[d] = 1'b0; haddr[d] = 32'd0; htrans[d] = 2'b00;
         hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = 32'd0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_hreadyout", 32'(hreadyout[d]), 32'd1);
         chk("reset_hresp", 32'(hresp[d]), 32'd0);
         chk("reset_hrdata", hrdata[d], 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Zero wait states: word, byte and halfword traffic.
      issue(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b1);
      issue(0, 32'h10, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b1);
      issue(0, 32'h10, 1'b1, 3'd2, 32'h11223344, 32'h0, 1'b0, 0, 1'b1);
      issue(0, 32'h13, 1'b1, 3'd0, 32'hAA000000, 32'h0, 1'b0, 0, 1'b1);
      issue(0, 32'h10, 1'b0, 3'd2, 32'h0, 32'hAA223344, 1'b0, 0, 1'b1);
      issue(0, 32'h12, 1'b1, 3'd1, 32'h55660000, 32'h0, 1'b0, 0, 1'b1);
      issue(0, 32'h10, 1'b0, 3'd2, 32'h0, 32'h55663344, 1'b0, 0, 1'b1);
`ifdef AHB_SRAM_ERR_EN
      issue(0, 32'h0, 1'b1, 3'd2, 32'h11111111, 32'h0, 1'b0, 0, 1'b1);
      issue(0, 32'h1000, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      issue(0, 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1);
      issue(0, 32'h0, 1'b0, 3'd2, 32'h0, 32'h11111111, 1'b0, 0, 1'b1);
`else
      issue(0, 32'h1000, 1'b1, 3'd2, 32'h00000001, 32'h0, 1'b0, 0, 1'b1);
      issue(0, 32'h0, 1'b0, 3'd2, 32'h0, 32'h00000001, 1'b0, 0, 1'b1);
`endif
      idle(0, 3);

      // Three wait states, pipelined address phases.
      issue(1, 32'h20, 1'b1, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0, 3, 1'b1);
      issue(1, 32'h24, 1'b1, 3'd2, 32'h12345678, 32'h0, 1'b0, 3, 1'b1);
      issue(1, 32'h20, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1);
      issue(1, 32'h24, 1'b0, 3'd2, 32'h0, 32'h12345678, 1'b0, 3, 1'b1);
      idle(1, 3);

      // Reset during a wait-state write drops the write.
      issue(1, 32'h20, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b0, 3, 1'b0);
      hsel[1] = 1'b0; htrans[1] = 2'b00;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midreset_hreadyout", 32'(hreadyout[1]), 32'd1);
      chk("midreset_hresp", 32'(hresp[1]), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      issue(1, 32'h20, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1);
      idle(1, 3);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite responder fronting a word-organised on-chip SRAM; the target end of the bus driven by the pipelined RV32I core's fetch, load and store traffic. It:
- accepts pipelined address phases and performs byte, halfword and word reads and writes;
- inserts a configurable number of wait states;
- optionally answers illegal accesses with the two-cycle AHB ERROR response.

## Interface
Parameters:
- DEPTH, 1024: memory size in 32-bit words; power of two.
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase, range 0..15.
- AW, $clog2(DEPTH): word-index width, derived; not overridden.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word.
- HBURST  in  3  ignored; every beat is handled independently.
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready, i.e. the muxed HREADYOUT of the selected slave.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1] = 1. On acceptance, register the address, write flag, size and error flag.
- Data phase FSM, states IDLE, WAIT, ERR1, ERR2:
  - IDLE: no pending transfer, or in the final cycle of one.
  - Accept, no error, WAIT_STATES > 0 → WAIT. Counter loads WAIT_STATES−1; stay until the counter reaches 0, then → IDLE. The transfer completes in the IDLE cycle with HREADYOUT = 1.
  - Accept, no error, WAIT_STATES = 0 → completes in the next cycle with HREADYOUT = 1.
  - Accept with error → ERR1, then ERR2, then IDLE. Any address phase in flight is re-evaluated from HREADY.
- HREADYOUT = 0 in WAIT and ERR1, 1 otherwise. HRESP = 1 in ERR1 and ERR2 only.
- IDLE/BUSY transfers, or HSEL = 0: no data phase; zero-wait OKAY.
- Write: on the completing data-phase cycle, store HWDATA byte lanes selected by HSIZE and HADDR[1:0]. Little-endian: byte lane = addr[1:0]; halfword lanes = addr[1] ? 3:2 : 1:0.
- Read: HRDATA = full word mem[addr[AW+1:2]] on the completing data-phase cycle. It is 0 in all other cycles. The array is read asynchronously from the registered index, so a read issued right after a write returns the new data.
- Wait-state or error cycles never modify memory.

## Timing
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM = IDLE, counter = 0. Memory contents are not reset.
- Latency: data is valid (OKAY) WAIT_STATES+1 cycles after the address-phase edge.
- Back-to-back NONSEQ/SEQ: the next address phase overlaps the completing data-phase cycle; sustained throughput is 1 transfer per WAIT_STATES+1 cycles.
- While HREADYOUT = 0 the slave ignores HADDR/HTRANS. It also ignores them while HREADY = 0 because another slave is stalling.
- Reset asserted mid-transfer: FSM returns to IDLE immediately and the pending write is dropped.

## Configuration
- AHB_SRAM_ERR_EN defined: an access is flagged as an error when:
  - the word index ≥ DEPTH (HADDR[31:AW+2] ≠ 0), or
  - HSIZE > 2, or
  - halfword with addr[0] = 1, or
  - word with addr[1:0] ≠ 0.
  A flagged access gets the two-cycle ERROR response, with no write and HRDATA = 0.
- AHB_SRAM_ERR_EN undefined:
  - no error detection; the ERR1/ERR2 logic is absent and HRESP is tied 0;
  - addresses wrap modulo DEPTH words;
  - misaligned accesses force the low address bits to zero for the given size;
  - HSIZE > 2 is treated as word.

## Structure
- Shared package ahb_pkg:
  - HTRANS encodings IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  - HSIZE_BYTE/HALF/WORD;
  - HRESP_OKAY/ERROR;
  - FSM state typedef.
- One sub-module, ahb_sram_mem: DEPTH×32 array with 4-bit byte-write enable, synchronous write and asynchronous read.
- Lane decode, FSM and counter live in the top.

## Test plan
- WAIT_STATES = 0:
  - word write 0xDEADBEEF to 0x10, then read 0x10 next cycle → HRDATA = 0xDEADBEEF, HREADYOUT never low.
  - byte write 0xAA to 0x13 over word 0x11223344 → read 0x10 returns 0xAA223344.
  - halfword write 0x5566 to 0x12 → upper half updated only.
- WAIT_STATES = 3: read 0x20 → HREADYOUT low exactly 3 cycles, data valid on the 4th cycle after the address phase; a pipelined second NONSEQ is accepted only on that cycle.
- ERR_EN defined, DEPTH = 1024: word read at 0x1000 → HRESP = 1 for 2 cycles with HREADYOUT 0 then 1. A word write to 0x2 also errors and leaves memory unchanged.
- Without ERR_EN: write 0x1 to 0x1000 → lands at word 0; reading 0x0 returns 0x00000001; HRESP stays 0.
- Assert reset during a WAIT-state write → HREADYOUT = 1, HRESP = 0 immediately, and the target word is unchanged afterwards.
